// File: rtl/cred_lookup_seq.sv
// ============================================================================
// Module   : cred_lookup_seq
// Purpose  : Scans the shared user/password ROM pair for a captured credential
//            pair and tracks consecutive failed attempts up to a lockout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cred_lookup_seq #(
    parameter int NUM_ENTRIES = 8,
    parameter int ROM_LATENCY = 2,
    parameter int MAX_FAILS   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] user_in,
    input  logic [19:0] pass_in,
    input  logic [15:0] user_rom_data,
    input  logic [19:0] pass_rom_data,
    output logic [7:0]  rom_addr,
    output logic        busy,
    output logic        done,
    output logic        user_found,
    output logic        auth_ok,
    output logic [7:0]  match_idx,
    output logic [3:0]  fail_cnt,
    output logic        locked
);

    localparam logic [7:0] LAST_IDX  = 8'(NUM_ENTRIES - 1);
    localparam logic [2:0] LAT_M1    = 3'(ROM_LATENCY - 1);
    localparam logic [3:0] MAX_FAILS_C = 4'(MAX_FAILS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CMP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [2:0]  wcnt_q,       wcnt_d;
    logic [15:0] user_cap_q,   user_cap_d;
    logic [19:0] pass_cap_q,   pass_cap_d;
    logic [7:0]  addr_q,       addr_d;
    logic        busy_q,       busy_d;
    logic        done_q,       done_d;
    logic        found_q,      found_d;
    logic        auth_q,       auth_d;
    logic [7:0]  idx_q,        idx_d;
    logic [3:0]  fail_q,       fail_d;
    logic        locked_q,     locked_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wcnt_q     <= 3'd0;
            user_cap_q <= 16'd0;
            pass_cap_q <= 20'd0;
            addr_q     <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            found_q    <= 1'b0;
            auth_q     <= 1'b0;
            idx_q      <= 8'd0;
            fail_q     <= 4'd0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            user_cap_q <= user_cap_d;
            pass_cap_q <= pass_cap_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            found_q    <= found_d;
            auth_q     <= auth_d;
            idx_q      <= idx_d;
            fail_q     <= fail_d;
            locked_q   <= locked_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        user_cap_d = user_cap_q;
        pass_cap_d = pass_cap_q;
        addr_d     = addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        found_d    = found_q;
        auth_d     = auth_q;
        idx_d      = idx_q;
        fail_d     = fail_q;
        locked_d   = locked_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !locked_q) begin
                    user_cap_d = user_in;
                    pass_cap_d = pass_in;
                    addr_d     = 8'd0;
                    busy_d     = 1'b1;
                    wcnt_d     = 3'd0;
                    found_d    = 1'b0;
                    auth_d     = 1'b0;
                    idx_d      = 8'd0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ROM data for the current address is valid after ROM_LATENCY edges here
                wcnt_d = wcnt_q + 3'd1;
                if (wcnt_q == LAT_M1) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (user_rom_data == user_cap_q) begin
                    found_d = 1'b1;
                    idx_d   = addr_q;
                    auth_d  = (pass_rom_data == pass_cap_q);
                    state_d = ST_FIN;
                end else if (addr_q != LAST_IDX) begin
                    addr_d  = addr_q + 8'd1;
                    wcnt_d  = 3'd0;
                    state_d = ST_WAIT;
                end else begin
                    found_d = 1'b0;
                    auth_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                addr_d  = 8'd0;
                state_d = ST_IDLE;
                if (auth_q) begin
                    fail_d = 4'd0;
                end else begin
                    // Count saturates so the lockout threshold is reached exactly once
                    fail_d = (fail_q >= MAX_FAILS_C) ? MAX_FAILS_C : fail_q + 4'd1;
                    if (fail_d == MAX_FAILS_C) begin
                        locked_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rom_addr   = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign user_found = found_q;
    assign auth_ok    = auth_q;
    assign match_idx  = idx_q;
    assign fail_cnt   = fail_q;
    assign locked     = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_cred_lookup_seq.sv
// ============================================================================
// Module   : tb_cred_lookup_seq
// Purpose  : Directed self-checking bench for cred_lookup_seq with a
//            two-stage ROM model (user 0x1000+i, password 0xA0000+i).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cred_lookup_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] user_in;
    logic [19:0] pass_in;
    logic [15:0] user_rom_data;
    logic [19:0] pass_rom_data;
    logic [7:0]  rom_addr;
    logic        busy;
    logic        done;
    logic        user_found;
    logic        auth_ok;
    logic [7:0]  match_idx;
    logic [3:0]  fail_cnt;
    logic        locked;

    int n_checks = 0;
    int n_errors = 0;

    cred_lookup_seq #(
        .NUM_ENTRIES(8),
        .ROM_LATENCY(2),
        .MAX_FAILS  (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .user_in      (user_in),
        .pass_in      (pass_in),
        .user_rom_data(user_rom_data),
        .pass_rom_data(pass_rom_data),
        .rom_addr     (rom_addr),
        .busy         (busy),
        .done         (done),
        .user_found   (user_found),
        .auth_ok      (auth_ok),
        .match_idx    (match_idx),
        .fail_cnt     (fail_cnt),
        .locked       (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-edge ROM: data for an address appears two edges after it is presented
    logic [15:0] r_user_s1;
    logic [19:0] r_pass_s1;
    always_ff @(posedge clk) begin
        r_user_s1     <= 16'h1000 + {8'h00, rom_addr};
        r_pass_s1     <= 20'hA0000 + {12'h000, rom_addr};
        user_rom_data <= r_user_s1;
        pass_rom_data <= r_pass_s1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one start and follows the scan to its done pulse.
    task automatic run_scan(input string tag, input logic [15:0] u, input logic [19:0] p,
                            input int exp_edge, input logic exp_found, input logic exp_auth,
                            input logic [7:0] exp_idx, input logic [3:0] exp_fail,
                            input logic exp_lock);
        int n;
        int bad;
        int exp_addr;
        int last;
        last = exp_found ? int'(exp_idx) : 7;
        start   = 1'b1;
        user_in = u;
        pass_in = p;
        tick();
        start   = 1'b0;
        user_in = 16'h1000;
        pass_in = 20'hA0000;
        check({tag, "_clr_found"}, {31'd0, user_found}, 32'd0);
        n   = 0;
        bad = 0;
        while (n < 60) begin
            if (done === 1'b1) break;
            exp_addr = n / 3;
            if (exp_addr > last) exp_addr = last;
            if (busy !== 1'b1 || int'(rom_addr) != exp_addr) bad++;
            tick();
            n++;
        end
        check({tag, "_done_edge"}, n, exp_edge);
        check({tag, "_addr_busy"}, bad, 0);
        check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check({tag, "_addr_end"}, {24'd0, rom_addr}, 32'd0);
        check({tag, "_found"}, {31'd0, user_found}, {31'd0, exp_found});
        check({tag, "_auth"}, {31'd0, auth_ok}, {31'd0, exp_auth});
        check({tag, "_idx"}, {24'd0, match_idx}, {24'd0, exp_idx});
        check({tag, "_fail"}, {28'd0, fail_cnt}, {28'd0, exp_fail});
        check({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_lock});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_found_hold"}, {31'd0, user_found}, {31'd0, exp_found});
    endtask

    // Counts any busy/done activity over a window while start is held.
    task automatic idle_window(input string tag, input logic [15:0] u, input logic [19:0] p);
        int bad;
        bad     = 0;
        start   = 1'b1;
        user_in = u;
        pass_in = p;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        start = 1'b0;
        check({tag, "_no_activity"}, bad, 0);
    endtask

    initial begin
        int n;
        int first_done;
        int second_done;
        int bad;
        rst     = 1'b0;
        start   = 1'b0;
        user_in = 16'h0;
        pass_in = 20'h0;
        tick();
        do_reset();

        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_outputs", {26'd0, busy, done, user_found, auth_ok, locked, 1'b0}, 32'd0);
        check("rst_idx", {24'd0, match_idx}, 32'd0);
        check("rst_fail", {28'd0, fail_cnt}, 32'd0);

        run_scan("m0",   16'h1000, 20'hA0000,  4, 1'b1, 1'b1, 8'd0, 4'd0, 1'b0);
        run_scan("m5",   16'h1005, 20'hA0005, 19, 1'b1, 1'b1, 8'd5, 4'd0, 1'b0);
        run_scan("bad3", 16'h1003, 20'hFFFFF, 13, 1'b1, 1'b0, 8'd3, 4'd1, 1'b0);
        run_scan("miss", 16'hBEEF, 20'hA0000, 25, 1'b0, 1'b0, 8'd0, 4'd2, 1'b0);
        run_scan("ok2",  16'h1002, 20'hA0002, 10, 1'b1, 1'b1, 8'd2, 4'd0, 1'b0);

        run_scan("lk1",  16'hBEEF, 20'h12345, 25, 1'b0, 1'b0, 8'd0, 4'd1, 1'b0);
        run_scan("lk2",  16'hBEEF, 20'h12345, 25, 1'b0, 1'b0, 8'd0, 4'd2, 1'b0);
        run_scan("lk3",  16'hBEEF, 20'h12345, 25, 1'b0, 1'b0, 8'd0, 4'd3, 1'b1);
        idle_window("lk4", 16'hBEEF, 20'h12345);
        idle_window("lkv", 16'h1001, 20'hA0001);
        check("lk_fail_held", {28'd0, fail_cnt}, 32'd3);
        do_reset();
        check("unlock_fail", {28'd0, fail_cnt}, 32'd0);
        check("unlock_locked", {31'd0, locked}, 32'd0);

        // Reset during WAIT at index 4, with start raised on the reset edge
        start   = 1'b1;
        user_in = 16'h1007;
        pass_in = 20'hA0007;
        tick();
        start   = 1'b0;
        for (int i = 0; i < 13; i++) tick();
        check("rw_addr_before", {24'd0, rom_addr}, 32'd4);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_addr", {24'd0, rom_addr}, 32'd0);
        tick();
        check("rw_not_accepted", {31'd0, busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("rw_no_done", bad, 0);
        check("rw_fail", {28'd0, fail_cnt}, 32'd0);

        // start held high: the second scan is accepted on the edge after FIN
        start   = 1'b1;
        user_in = 16'h1000;
        pass_in = 20'hA0000;
        tick();
        n = 0;
        first_done  = -1;
        second_done = -1;
        while (n < 40 && second_done < 0) begin
            if (done === 1'b1) begin
                if (first_done < 0) first_done = n;
                else second_done = n;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check("hold_first", first_done, 4);
        check("hold_second", second_done, 9);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cred_lookup_seq.md
Name: cred_lookup_seq

Overview:
- Sequencer that owns the shared credential ROM pair: the 16-bit user ROM and the 20-bit password ROM.
- On a start request it scans the entries, compares against a captured user ID/password pair, and reports found / authorised / index.
- Counts consecutive failed attempts and locks out further requests after a limit.
- Sits between the switch-entry front end and the game-enable logic.

Parameters:
NUM_ENTRIES, 8, number of ROM entries scanned (1..256)
ROM_LATENCY, 2, clock edges from rom_addr change to valid ROM data (1..4)
MAX_FAILS, 3, consecutive failed attempts that set lockout (1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  lookup request; sampled only in IDLE
user_in  input  16  user ID to match
pass_in  input  20  password to match
user_rom_data  input  16  user ROM output
pass_rom_data  input  20  password ROM output
rom_addr  output  8  registered address, drives both ROMs
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle completion pulse
user_found  output  1  user ID matched an entry
auth_ok  output  1  user matched and password at the same index matched
match_idx  output  8  index of first user match (0 if none)
fail_cnt  output  4  consecutive failed attempts
locked  output  1  lockout active; start ignored

Behaviour:
- Reset values (rst=1 at an edge): every output is 0, including rom_addr, busy, done, user_found, auth_ok, match_idx, fail_cnt and locked. State goes to IDLE; the wait counter and capture registers clear.
- Reset mid-scan aborts the scan immediately. No done pulse and no fail_cnt update occur.
- States: IDLE, WAIT, CMP, FIN.
- IDLE:
  - If start=1 and locked=0: capture user_in/pass_in, rom_addr<=0, busy<=1, wcnt<=0, then go to WAIT.
  - Starting a new scan also clears user_found, auth_ok and match_idx.
  - start while locked=1 is ignored: no state change, no counter change.
- WAIT: wcnt increments each cycle. On the ROM_LATENCY-th edge in WAIT, go to CMP.
- CMP compares the captured values against the ROM data in that cycle:
  - User match: user_found<=1, match_idx<=rom_addr, auth_ok<=(pass_rom_data==captured pass), go to FIN.
  - No match, rom_addr<NUM_ENTRIES-1: rom_addr<=rom_addr+1, wcnt<=0, go to WAIT.
  - No match, rom_addr==NUM_ENTRIES-1: user_found<=0, auth_ok<=0, go to FIN.
- The first match wins; duplicate user IDs at later indices are never examined.
- FIN (one cycle): done<=1 (cleared next cycle), busy<=0, rom_addr<=0, go to IDLE. The results are registered on this same edge.
- Result registers hold until the next accepted start or reset.
- Failure accounting, updated on the FIN edge:
  - auth_ok=1: fail_cnt<=0.
  - Otherwise fail_cnt saturates at MAX_FAILS; locked<=1 when the new count equals MAX_FAILS.
  - locked clears only by rst.
- Latency: a match at index k gives done high during the cycle after edge (k+1)(ROM_LATENCY+1)+1, counted from the accepting edge (edge 0). A full miss gives done after edge NUM_ENTRIES(ROM_LATENCY+1)+1.
- Input stability: start, user_in and pass_in changing while busy=1 have no effect.
- start held high continuously starts a new scan on the edge after FIN returns to IDLE. No back-to-back acceptance happens in the FIN cycle.
- rom_addr never exceeds NUM_ENTRIES-1 (no wrap).
- rst and start on the same edge: reset wins.

Test Plan:
- ROM user IDs 0x1000+i and passwords 0xA0000+i, i=0..7, ROM_LATENCY=2. Start with user 0x1000, pass 0xA0000 -> done 1 cycle, 3 cycles after edge 0 plus FIN (edge 4); user_found=1, auth_ok=1, match_idx=0, fail_cnt=0.
- Same ROM, user 0x1005, pass 0xA0005 -> done after edge 19, match_idx=5, auth_ok=1. rom_addr steps 0..5, each held 3 cycles.
- User 0x1003, pass 0xFFFFF -> user_found=1, auth_ok=0, match_idx=3, fail_cnt=1.
- Three starts with user 0xBEEF (absent) -> each done after edge 25 with user_found=0; fail_cnt 1,2,3 and locked=1 after the third. A fourth start produces no busy and no done. A later valid pair is still ignored until rst; after rst, fail_cnt=0 and locked=0.
- Two failures, then a valid login 0x1002/0xA0002 -> fail_cnt returns to 0, locked stays 0.
- Assert rst during WAIT at index 4 -> next cycle busy=0, rom_addr=0, no done pulse, fail_cnt unchanged at 0. A start on the same edge as rst is not accepted.
